// File: rtl/racc_pkg.sv
// Shared types for the tile reduce accumulator: tile mode, per-beat sideband,
// and the saturating add used when TILE_REDUCE_ACC_SAT_EN is defined.
package racc_pkg;

  typedef enum logic [1:0] {
    MODE_MAC     = 2'b00,
    MODE_OUTER   = 2'b01,
    MODE_MAC_RUN = 2'b10
  } mode_e;

  typedef struct packed {
    logic  valid;
    mode_e mode;
    logic  first;
    logic  last;
  } sb_t;

  localparam int SB_W = $bits(sb_t);

  typedef struct packed {
    logic        sat;
    logic [63:0] val;
  } sat_res_t;

  // Operands arrive sign-extended to 64 bits; result is clamped to a w-bit signed range.
  function automatic sat_res_t sat_add(input logic signed [63:0] a,
                                       input logic signed [63:0] b,
                                       input int unsigned w);
    logic signed [64:0] s, mx, mn;
    sat_res_t r;
    s  = {a[63], a} + {b[63], b};
    mx = (65'sd1 <<< (w - 1)) - 65'sd1;
    mn = -(65'sd1 <<< (w - 1));
    r.sat = 1'b0;
    r.val = s[63:0];
    if (s > mx) begin
      r.sat = 1'b1;
      r.val = mx[63:0];
    end else if (s < mn) begin
      r.sat = 1'b1;
      r.val = mn[63:0];
    end
    return r;
  endfunction

endpackage

// File: rtl/racc_adder_level.sv
// One registered pairwise reduction level: rows 2r and 2r+1 summed per column,
// registered together with the beat sideband; holds when en_i is low.
module racc_adder_level
  import racc_pkg::*;
#(
  parameter int ROWS_OUT = 2,
  parameter int COLS     = 4,
  parameter int W        = 32
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         en_i,
  input  logic [SB_W-1:0]              sb_i,
  input  logic [2*ROWS_OUT*COLS*W-1:0] dat_i,
  output logic [SB_W-1:0]              sb_o,
  output logic [ROWS_OUT*COLS*W-1:0]   dat_o
);

  logic [SB_W-1:0]            sb_q;
  logic [ROWS_OUT*COLS*W-1:0] dat_q, dat_d;

  always_comb begin
    dat_d = '0;
    for (int r = 0; r < ROWS_OUT; r++) begin
      for (int c = 0; c < COLS; c++) begin
        dat_d[(r*COLS+c)*W +: W] = dat_i[((2*r)*COLS+c)*W +: W] + dat_i[((2*r+1)*COLS+c)*W +: W];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sb_q  <= '0;
      dat_q <= '0;
    end else if (en_i) begin
      sb_q  <= sb_i;
      dat_q <= dat_d;
    end
  end

  assign sb_o  = sb_q;
  assign dat_o = dat_q;

endmodule

// File: rtl/tile_reduce_accumulator.sv
// Column-reduces a TILE_ROWS x TILE_COLS beat through a registered adder tree and
// accumulates per tile (MAC / MAC_RUN) or passes through (OUTER). Optional: TILE_REDUCE_ACC_SAT_EN.
module tile_reduce_accumulator
  import racc_pkg::*;
#(
  parameter int TILE_ROWS = 4,
  parameter int TILE_COLS = 4,
  parameter int IN_WIDTH  = 32,
  parameter int ACC_WIDTH = 32,
  parameter int CNT_WIDTH = 16
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic [1:0]                        in_mode,
  input  logic                              in_first,
  input  logic                              in_last,
  input  logic [TILE_ROWS*TILE_COLS*IN_WIDTH-1:0] mat_in,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic [TILE_COLS*ACC_WIDTH-1:0]    vec_out,
  output logic [CNT_WIDTH-1:0]              out_beats,
`ifdef TILE_REDUCE_ACC_SAT_EN
  output logic [TILE_COLS-1:0]              sat_flag,
`endif
  output logic                              err_frame
);

  localparam int L = $clog2(TILE_ROWS);
  localparam int N = TILE_ROWS * TILE_COLS;

  logic  stall, take;
  logic  open_q, open_d, err_q, err_d, eff_first;
  mode_e mode_q, mode_d, in_mode_m;
  sb_t   sb0, sbl;
  logic [N*ACC_WIDTH-1:0]         sext;
  logic [TILE_COLS*ACC_WIDTH-1:0] col_sum, acc_q, acc_d;
  logic [CNT_WIDTH-1:0]           cnt_q, cnt_d;
  logic                           ov_q, ov_d;

  assign stall = ov_q && !out_ready;
  assign take  = in_valid && !stall;

  // Reserved encoding 11 behaves as OUTER.
  always_comb begin
    case (in_mode)
      2'b00:   in_mode_m = MODE_MAC;
      2'b10:   in_mode_m = MODE_MAC_RUN;
      default: in_mode_m = MODE_OUTER;
    endcase
  end

  always_comb begin
    open_d    = open_q;
    err_d     = err_q;
    mode_d    = mode_q;
    eff_first = in_first || !open_q;
    if (take) begin
      if (!in_first && !open_q) err_d = 1'b1;
      if (in_first && open_q)   err_d = 1'b1;
      if (!eff_first && in_mode_m != mode_q) err_d = 1'b1;
      if (eff_first) mode_d = in_mode_m;
      open_d = !in_last;
    end
    sb0.valid = take;
    sb0.mode  = eff_first ? in_mode_m : mode_q;
    sb0.first = eff_first;
    sb0.last  = in_last;
  end

  always_comb begin
    sext = '0;
    for (int i = 0; i < N; i++) begin
      sext[i*ACC_WIDTH +: ACC_WIDTH] = ACC_WIDTH'($signed(mat_in[i*IN_WIDTH +: IN_WIDTH]));
    end
  end

  for (genvar k = 0; k < L; k++) begin : g_lvl
    localparam int RO = TILE_ROWS >> (k + 1);
    logic [SB_W-1:0]             sb;
    logic [RO*TILE_COLS*ACC_WIDTH-1:0] dat;
    if (k == 0) begin : g_src
      racc_adder_level #(.ROWS_OUT(RO), .COLS(TILE_COLS), .W(ACC_WIDTH)) u_lvl (
        .clk(clk), .rst(rst), .en_i(!stall), .sb_i(sb0), .dat_i(sext),
        .sb_o(sb), .dat_o(dat));
    end else begin : g_src
      racc_adder_level #(.ROWS_OUT(RO), .COLS(TILE_COLS), .W(ACC_WIDTH)) u_lvl (
        .clk(clk), .rst(rst), .en_i(!stall), .sb_i(g_lvl[k-1].sb), .dat_i(g_lvl[k-1].dat),
        .sb_o(sb), .dat_o(dat));
    end
  end

  assign sbl     = sb_t'(g_lvl[L-1].sb);
  assign col_sum = g_lvl[L-1].dat;

`ifdef TILE_REDUCE_ACC_SAT_EN
  logic [TILE_COLS-1:0] sat_q, sat_d;
  sat_res_t             sr;
`endif

  always_comb begin
    acc_d = acc_q;
    cnt_d = cnt_q;
    ov_d  = ov_q;
`ifdef TILE_REDUCE_ACC_SAT_EN
    sat_d = sat_q;
    sr    = '0;
`endif
    if (!stall) begin
      ov_d = sbl.valid && (sbl.mode != MODE_MAC || sbl.last);
      if (sbl.valid) begin
        if (sbl.first || sbl.mode == MODE_OUTER) begin
          acc_d = col_sum;
          cnt_d = CNT_WIDTH'(1);
`ifdef TILE_REDUCE_ACC_SAT_EN
          if (sbl.first) sat_d = '0;
`endif
        end else begin
          if (cnt_q != '1) cnt_d = cnt_q + CNT_WIDTH'(1);
          for (int c = 0; c < TILE_COLS; c++) begin
`ifdef TILE_REDUCE_ACC_SAT_EN
            sr = sat_add(64'($signed(acc_q[c*ACC_WIDTH +: ACC_WIDTH])),
                         64'($signed(col_sum[c*ACC_WIDTH +: ACC_WIDTH])), ACC_WIDTH);
            acc_d[c*ACC_WIDTH +: ACC_WIDTH] = sr.val[ACC_WIDTH-1:0];
            sat_d[c] = sat_q[c] | sr.sat;
`else
            acc_d[c*ACC_WIDTH +: ACC_WIDTH] = acc_q[c*ACC_WIDTH +: ACC_WIDTH] + col_sum[c*ACC_WIDTH +: ACC_WIDTH];
`endif
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      open_q <= 1'b0;
      err_q  <= 1'b0;
      mode_q <= MODE_MAC;
      acc_q  <= '0;
      cnt_q  <= '0;
      ov_q   <= 1'b0;
`ifdef TILE_REDUCE_ACC_SAT_EN
      sat_q  <= '0;
`endif
    end else begin
      open_q <= open_d;
      err_q  <= err_d;
      mode_q <= mode_d;
      acc_q  <= acc_d;
      cnt_q  <= cnt_d;
      ov_q   <= ov_d;
`ifdef TILE_REDUCE_ACC_SAT_EN
      sat_q  <= sat_d;
`endif
    end
  end

  assign in_ready  = !stall;
  assign out_valid = ov_q;
  assign vec_out   = acc_q;
  assign out_beats = cnt_q;
  assign err_frame = err_q;
`ifdef TILE_REDUCE_ACC_SAT_EN
  assign sat_flag  = sat_q;
`endif

endmodule

// File: tb/tb_tile_reduce_accumulator.sv
// Scoreboard bench for tile_reduce_accumulator at default parameters; stimulus
// pushes expected results, a negedge monitor pops and compares on each handshake.
module tb_tile_reduce_accumulator;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0, in_first = 1'b0, in_last = 1'b0, out_ready = 1'b1;
  logic [1:0]   in_mode = 2'b00;
  logic [511:0] mat_in = '0;
  logic         in_ready, out_valid, err_frame;
  logic [127:0] vec_out;
  logic [15:0]  out_beats;
`ifdef TILE_REDUCE_ACC_SAT_EN
  logic [3:0]   sat_flag;
`endif

  typedef struct {
    logic [127:0] vec;
    logic [15:0]  beats;
    logic         sat_chk;
    logic [3:0]   sat;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  tile_reduce_accumulator dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_mode(in_mode),
    .in_first(in_first), .in_last(in_last), .mat_in(mat_in), .out_valid(out_valid),
    .out_ready(out_ready), .vec_out(vec_out), .out_beats(out_beats),
`ifdef TILE_REDUCE_ACC_SAT_EN
    .sat_flag(sat_flag),
`endif
    .err_frame(err_frame));

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] want);
    n_cmp++;
    if (act !== want) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, want);
    end
  endtask

  function automatic logic [511:0] fill(input logic [31:0] v);
    logic [511:0] m;
    for (int i = 0; i < 16; i++) m[i*32 +: 32] = v;
    return m;
  endfunction

  function automatic logic [511:0] rc_mat();
    logic [511:0] m;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) m[(r*4+c)*32 +: 32] = 32'(r + c);
    return m;
  endfunction

  function automatic logic [127:0] lanes(input logic [31:0] a, b, c, d);
    return {d, c, b, a};
  endfunction

  task automatic expect_out(input logic [127:0] v, input logic [15:0] b);
    exp_t e;
    e.vec = v; e.beats = b; e.sat_chk = 1'b0; e.sat = '0;
    exp_q.push_back(e);
  endtask

  task automatic send(input logic [1:0] m, input logic f, input logic l, input logic [511:0] d);
    int t = 0;
    @(negedge clk);
    in_valid = 1'b1; in_mode = m; in_first = f; in_last = l; mat_in = d;
    while (!in_ready && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (t >= 100) begin
      n_cmp++; n_bad++;
      $display("FAIL send_timeout: in_ready stayed 0 for %0d cycles, expected 1", t);
    end
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic drain();
    int t = 0;
    while (exp_q.size() != 0 && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (exp_q.size() != 0) begin
      n_cmp++; n_bad++;
      $display("FAIL drain_timeout: %0d results outstanding, expected 0", exp_q.size());
      exp_q.delete();
    end
    repeat (3) @(negedge clk);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL unexpected_output: got vec %h, expected no output", vec_out);
      end else begin
        e = exp_q.pop_front();
        chk("vec_out", vec_out, e.vec);
        chk("out_beats", 128'(out_beats), 128'(e.beats));
`ifdef TILE_REDUCE_ACC_SAT_EN
        if (e.sat_chk) chk("sat_flag", 128'(sat_flag), 128'(e.sat));
`endif
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_in_ready", 128'(in_ready), 128'(1));
    chk("rst_out_valid", 128'(out_valid), 128'(0));
    chk("rst_vec_out", vec_out, '0);
    chk("rst_out_beats", 128'(out_beats), '0);
    chk("rst_err_frame", 128'(err_frame), '0);

    // MAC, 3 beats of ones; result 3 cycles after the last beat is presented
    expect_out(lanes(12, 12, 12, 12), 16'd3);
    send(2'b00, 1'b1, 1'b0, fill(1));
    send(2'b00, 1'b0, 1'b0, fill(1));
    send(2'b00, 1'b0, 1'b1, fill(1));
    @(negedge clk); chk("lat_c1_out_valid", 128'(out_valid), 128'(0));
    @(negedge clk); chk("lat_c2_out_valid", 128'(out_valid), 128'(0));
    @(negedge clk); chk("lat_c3_out_valid", 128'(out_valid), 128'(1));
    drain();

    // OUTER: r+c matrix, then a negative beat
    expect_out(lanes(6, 10, 14, 18), 16'd1);
    expect_out(lanes(6, 10, 14, 18), 16'd1);
    expect_out(lanes(32'hFFFF_FFFC, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 32'hFFFF_FFFC), 16'd1);
    send(2'b01, 1'b1, 1'b0, rc_mat());
    send(2'b01, 1'b0, 1'b0, rc_mat());
    send(2'b01, 1'b0, 1'b1, fill(32'hFFFF_FFFF));
    drain();

    // MAC_RUN with a 4-cycle downstream stall on the second result
    expect_out(lanes(8, 8, 8, 8), 16'd1);
    expect_out(lanes(16, 16, 16, 16), 16'd2);
    expect_out(lanes(24, 24, 24, 24), 16'd3);
    fork
      begin
        send(2'b10, 1'b1, 1'b0, fill(2));
        send(2'b10, 1'b0, 1'b0, fill(2));
        send(2'b10, 1'b0, 1'b1, fill(2));
      end
      begin
        t = 0;
        do begin
          @(posedge clk); #2;
          t++;
        end while (!out_valid && t < 50);
        @(posedge clk); #2;
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
          @(negedge clk);
          chk("stall_in_ready", 128'(in_ready), 128'(0));
          chk("stall_out_valid", 128'(out_valid), 128'(1));
          chk("stall_vec_held", vec_out, lanes(16, 16, 16, 16));
        end
        out_ready = 1'b1;
      end
    join
    drain();
    chk("clean_err_frame", 128'(err_frame), '0);

    // Beat without first while no tile is open: treated as first, flags error
    expect_out(lanes(20, 20, 20, 20), 16'd1);
    send(2'b00, 1'b0, 1'b1, fill(5));
    drain();
    chk("frame_err_set", 128'(err_frame), 128'(1));
    repeat (5) @(negedge clk);
    chk("frame_err_sticky", 128'(err_frame), 128'(1));

    // Reset mid-tile discards partial state, then a clean one-beat tile
    send(2'b00, 1'b1, 1'b0, fill(1));
    send(2'b00, 1'b0, 1'b0, fill(1));
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    chk("rst2_out_valid", 128'(out_valid), 128'(0));
    chk("rst2_vec_out", vec_out, '0);
    chk("rst2_out_beats", 128'(out_beats), '0);
    chk("rst2_err_frame", 128'(err_frame), '0);
    repeat (5) @(negedge clk);
    expect_out(lanes(4, 4, 4, 4), 16'd1);
    send(2'b00, 1'b1, 1'b1, fill(1));
    drain();
    chk("post_rst_err_frame", 128'(err_frame), '0);

`ifdef TILE_REDUCE_ACC_SAT_EN
    begin
      exp_t e;
      e.vec = lanes(32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h7FFF_FFFF);
      e.beats = 16'd2; e.sat_chk = 1'b1; e.sat = 4'hF;
      exp_q.push_back(e);
      send(2'b00, 1'b1, 1'b0, fill(32'h1C00_0000));
      send(2'b00, 1'b0, 1'b1, fill(32'h1C00_0000));
      drain();
    end
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
